// File: rtl/instr_encoder_loader_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_if
//   Symbolic-instruction stream carried from a program source into the
//   instruction encoder/loader over a valid/ready handshake.
//
//   in_valid  producer -> loader   instruction offered
//   in_ready  loader -> producer   instruction taken when in_valid & in_ready
//   op_sel    producer -> loader   operation select (0 JMR .. 15 STP)
//   rd, rs    producer -> loader   register fields
//   imm       producer -> loader   immediate / absolute address
// -----------------------------------------------------------------------------
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [15:0] imm;

  modport master (output in_valid, op_sel, rd, rs, imm, input in_ready);
  modport slave  (input in_valid, op_sel, rd, rs, imm, output in_ready);
endinterface

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//   Inverse of the CPU instruction decoder: accepts symbolic instructions,
//   encodes them into 16-bit words and writes them sequentially into the
//   instruction RAM. SIM takes two words (opcode word, then the immediate),
//   mirroring the decoder's extra fetch state. Used for boot/program load.
//
//   Optional feature macro: ENC_RANGE_CHECK_EN
//     defined   : JMD/CALL/LDA with imm[15:12] != 0 are accepted but dropped,
//                 and err_o pulses for one cycle.
//     undefined : imm[15:12] is silently truncated; err_o stays 0.
//
// Parameters
//   ADDR_W  instruction RAM address width
//   DEPTH   usable words (<= 2**ADDR_W); the write pointer never passes it
//
// Ports
//   clk               clock, rising edge
//   rst_n             synchronous reset, active-low
//   in_if             instruction stream (slave side of the handshake)
//   start_i           synchronous clear of pointer/count, aborts in-flight words
//   instr_addr_o      RAM write address (holds when not writing)
//   instr_data_o      RAM write data (holds when not writing)
//   ram_wren_instr_o  RAM write strobe, one cycle per word
//   busy_o            a word write is in progress
//   full_o            count_o == DEPTH
//   count_o           words written since reset/start
//   err_o             one-cycle range-error pulse
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_encoder_loader_if.slave in_if,
  input  logic                  start_i,
  output logic [ADDR_W-1:0]     instr_addr_o,
  output logic [15:0]           instr_data_o,
  output logic                  ram_wren_instr_o,
  output logic                  busy_o,
  output logic                  full_o,
  output logic [ADDR_W:0]       count_o,
  output logic                  err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR1  = 2'd1;
  localparam logic [1:0] ST_WR2  = 2'd2;

  localparam logic [3:0] OP_JMR   = 4'd0;
  localparam logic [3:0] OP_INC   = 4'd1;
  localparam logic [3:0] OP_DEC   = 4'd2;
  localparam logic [3:0] OP_SIM   = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_MOV   = 4'd6;
  localparam logic [3:0] OP_PUSH  = 4'd7;
  localparam logic [3:0] OP_POP   = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_JMD   = 4'd11;
  localparam logic [3:0] OP_CALL  = 4'd12;
  localparam logic [3:0] OP_LDA   = 4'd13;
  localparam logic [3:0] OP_RTN   = 4'd14;
  localparam logic [3:0] OP_STP   = 4'd15;

  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO_C = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   CNT_ONE_C  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE_C = ADDR_W'(1);

  // First (or only) instruction word; unused low bits are zero.
  function automatic logic [15:0] enc_word1(input logic [3:0]  op,
                                            input logic [2:0]  rd,
                                            input logic [2:0]  rs,
                                            input logic [11:0] imm_lo);
    logic [15:0] w;
    w = 16'h0000;
    case (op)
      OP_JMR:   w = {9'b000000000, rd, 4'b0000};
      OP_INC:   w = {9'b000001000, rd, 4'b0000};
      OP_DEC:   w = {9'b000001001, rd, 4'b0000};
      OP_SIM:   w = {9'b000001100, rd, 4'b0000};
      OP_ADD:   w = {6'b010000, rd, rs, 4'b0000};
      OP_SUB:   w = {6'b010010, rd, rs, 4'b0000};
      OP_MOV:   w = {6'b010110, rd, rs, 4'b0000};
      OP_PUSH:  w = {6'b011000, rd, rs, 4'b0000};
      OP_POP:   w = {6'b011010, rd, rs, 4'b0000};
      OP_STORE: w = {6'b011011, rd, rs, 4'b0000};
      OP_MUL:   w = {3'b100, 3'b000, rd, rs, 4'b0000};
      OP_JMD:   w = {4'b1100, imm_lo};
      OP_CALL:  w = {4'b1101, imm_lo};
      OP_LDA:   w = {4'b1110, imm_lo};
      OP_RTN:   w = 16'hF000;
      OP_STP:   w = 16'hF010;
      default:  w = 16'h0000;
    endcase
    return w;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       imm_q, imm_d;
  logic              sim_q, sim_d;
  logic              err_q, err_d;

  logic [ADDR_W:0]   free_s;
  logic              is_sim_s;
  logic              ready_s;
  logic              accept_s;
  logic              range_bad_s;

  assign free_s   = DEPTH_C - count_q;
  assign is_sim_s = (in_if.op_sel == OP_SIM);
  // A SIM needs two free slots so it never straddles the full boundary.
  assign ready_s  = (state_q == ST_IDLE) && !start_i && (free_s != CNT_ZERO_C) &&
                    !(is_sim_s && (free_s == CNT_ONE_C));
  assign accept_s = in_if.in_valid && ready_s;

`ifdef ENC_RANGE_CHECK_EN
  assign range_bad_s = ((in_if.op_sel == OP_JMD) || (in_if.op_sel == OP_CALL) ||
                        (in_if.op_sel == OP_LDA)) && (in_if.imm[15:12] != 4'h0);
`else
  assign range_bad_s = 1'b0;
`endif

  // Next-state logic: start dominates, then the accept/WR1/WR2 sequence.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    imm_d   = imm_q;
    sim_d   = sim_q;
    err_d   = 1'b0;
    if (start_i) begin
      state_d = ST_IDLE;
      count_d = CNT_ZERO_C;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            if (range_bad_s) begin
              // Handshake completes but nothing is written.
              err_d = 1'b1;
            end else begin
              state_d = ST_WR1;
              addr_d  = count_q[ADDR_W-1:0];
              data_d  = enc_word1(in_if.op_sel, in_if.rd, in_if.rs, in_if.imm[11:0]);
              imm_d   = in_if.imm;
              sim_d   = is_sim_s;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WR1: begin
          count_d = count_q + CNT_ONE_C;
          if (sim_q) begin
            // Second SIM word goes to the next address.
            state_d = ST_WR2;
            addr_d  = addr_q + ADDR_ONE_C;
            data_d  = imm_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WR2: begin
          count_d = count_q + CNT_ONE_C;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= CNT_ZERO_C;
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= 16'h0000;
      imm_q   <= 16'h0000;
      sim_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      imm_q   <= imm_d;
      sim_q   <= sim_d;
      err_q   <= err_d;
    end
  end

  assign in_if.in_ready   = ready_s;
  assign instr_addr_o     = addr_q;
  assign instr_data_o     = data_q;
  // start must suppress the word in the very cycle it is raised.
  assign ram_wren_instr_o = ((state_q == ST_WR1) || (state_q == ST_WR2)) && !start_i;
  assign busy_o           = (state_q != ST_IDLE);
  assign full_o           = (count_q == DEPTH_C);
  assign count_o          = count_q;
  assign err_o            = err_q;

endmodule
